// File: rtl/axis_vlan_ingress_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : axis_vlan_ingress_arbiter
// Brief   : Frame-granular round-robin arbiter sharing one VLAN tag decoder
//           between NUM_PORTS AXI-Stream ingress ports. Optional stall timeout
//           is enabled with VLAN_INGRESS_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module axis_vlan_ingress_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_BITS = $clog2(NUM_PORTS),
  parameter int TIMEOUT   = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0][31:0] axi_rx_tdata,
  input  logic [NUM_PORTS-1:0]       axi_rx_tvalid,
  input  logic [NUM_PORTS-1:0]       axi_rx_tlast,
  input  logic [NUM_PORTS-1:0]       axi_rx_tuser,
  output logic [NUM_PORTS-1:0]       axi_rx_tready,
  output logic [31:0]                axi_tx_tdata,
  output logic                       axi_tx_tvalid,
  output logic                       axi_tx_tlast,
  output logic                       axi_tx_tuser,
  input  logic                       axi_tx_tready,
  input  logic [NUM_PORTS-1:0][11:0] cfg_port_vlan,
  input  logic [NUM_PORTS-1:0]       cfg_drop_tagged,
  input  logic [NUM_PORTS-1:0]       cfg_drop_untagged,
  output logic [11:0]                port_vlan,
  output logic                       drop_tagged,
  output logic                       drop_untagged,
  output logic [PORT_BITS-1:0]       active_port,
  output logic                       busy
);

  if (NUM_PORTS < 2 || NUM_PORTS > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("axis_vlan_ingress_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FORWARD = 2'd1
`ifdef VLAN_INGRESS_ARB_TIMEOUT_EN
    , S_DISCARD = 2'd2
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [PORT_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [PORT_BITS-1:0] active_port_q, active_port_d;
  logic                 busy_q, busy_d;
  logic [11:0]          port_vlan_q, port_vlan_d;
  logic                 drop_tagged_q, drop_tagged_d;
  logic                 drop_untagged_q, drop_untagged_d;
`ifdef VLAN_INGRESS_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
  logic [15:0]          stall_cnt_q, stall_cnt_d;
`endif

  logic                 req_found;
  logic [PORT_BITS-1:0] req_sel;
  logic [PORT_BITS-1:0] next_ptr;
  logic                 sel_valid;
  logic                 sel_last;

  // First requesting port at or after rr_ptr, wrapping around.
  always_comb begin : p_rr_search
    int cand;
    cand      = 0;
    req_found = 1'b0;
    req_sel   = rr_ptr_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_PORTS;
      if (!req_found && axi_rx_tvalid[cand[PORT_BITS-1:0]]) begin
        req_found = 1'b1;
        req_sel   = cand[PORT_BITS-1:0];
      end
    end
  end

  assign sel_valid = axi_rx_tvalid[active_port_q];
  assign sel_last  = axi_rx_tlast[active_port_q];
  assign next_ptr  = (active_port_q == PORT_BITS'(NUM_PORTS - 1)) ? '0
                   : active_port_q + PORT_BITS'(1);

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    active_port_d   = active_port_q;
    busy_d          = busy_q;
    port_vlan_d     = port_vlan_q;
    drop_tagged_d   = drop_tagged_q;
    drop_untagged_d = drop_untagged_q;
`ifdef VLAN_INGRESS_ARB_TIMEOUT_EN
    stall_cnt_d     = stall_cnt_q;
`endif
    axi_rx_tready   = '0;
    axi_tx_tvalid   = 1'b0;
    axi_tx_tdata    = '0;
    axi_tx_tlast    = 1'b0;
    axi_tx_tuser    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_found) begin
          state_d         = S_FORWARD;
          active_port_d   = req_sel;
          busy_d          = 1'b1;
          port_vlan_d     = cfg_port_vlan[req_sel];
          drop_tagged_d   = cfg_drop_tagged[req_sel];
          drop_untagged_d = cfg_drop_untagged[req_sel];
`ifdef VLAN_INGRESS_ARB_TIMEOUT_EN
          stall_cnt_d     = '0;
`endif
        end
      end

      S_FORWARD: begin
`ifdef VLAN_INGRESS_ARB_TIMEOUT_EN
        if (stall_cnt_q == TIMEOUT_CNT) begin
          // Terminate the stalled frame with an errored tail beat.
          axi_tx_tvalid = 1'b1;
          axi_tx_tlast  = 1'b1;
          axi_tx_tuser  = 1'b1;
          if (axi_tx_tready) begin
            state_d     = S_DISCARD;
            stall_cnt_d = '0;
          end
        end else begin
          axi_tx_tvalid                = sel_valid;
          axi_tx_tdata                 = axi_rx_tdata[active_port_q];
          axi_tx_tlast                 = sel_last;
          axi_tx_tuser                 = axi_rx_tuser[active_port_q];
          axi_rx_tready[active_port_q] = axi_tx_tready;
          stall_cnt_d = sel_valid ? '0 : stall_cnt_q + 16'd1;
          if (sel_valid && sel_last && axi_tx_tready) begin
            state_d  = S_IDLE;
            rr_ptr_d = next_ptr;
            busy_d   = 1'b0;
          end
        end
`else
        axi_tx_tvalid                = sel_valid;
        axi_tx_tdata                 = axi_rx_tdata[active_port_q];
        axi_tx_tlast                 = sel_last;
        axi_tx_tuser                 = axi_rx_tuser[active_port_q];
        axi_rx_tready[active_port_q] = axi_tx_tready;
        if (sel_valid && sel_last && axi_tx_tready) begin
          state_d  = S_IDLE;
          rr_ptr_d = next_ptr;
          busy_d   = 1'b0;
        end
`endif
      end

`ifdef VLAN_INGRESS_ARB_TIMEOUT_EN
      S_DISCARD: begin
        axi_rx_tready[active_port_q] = 1'b1;
        if (sel_valid && sel_last) begin
          state_d  = S_IDLE;
          rr_ptr_d = next_ptr;
          busy_d   = 1'b0;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      rr_ptr_q        <= '0;
      active_port_q   <= '0;
      busy_q          <= 1'b0;
      port_vlan_q     <= '0;
      drop_tagged_q   <= 1'b0;
      drop_untagged_q <= 1'b0;
`ifdef VLAN_INGRESS_ARB_TIMEOUT_EN
      stall_cnt_q     <= '0;
`endif
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      active_port_q   <= active_port_d;
      busy_q          <= busy_d;
      port_vlan_q     <= port_vlan_d;
      drop_tagged_q   <= drop_tagged_d;
      drop_untagged_q <= drop_untagged_d;
`ifdef VLAN_INGRESS_ARB_TIMEOUT_EN
      stall_cnt_q     <= stall_cnt_d;
`endif
    end
  end

  assign port_vlan     = port_vlan_q;
  assign drop_tagged   = drop_tagged_q;
  assign drop_untagged = drop_untagged_q;
  assign active_port   = active_port_q;
  assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_vlan_ingress_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_axis_vlan_ingress_arbiter
// Brief   : Self-checking bench: arbitration vector table plus scoreboarded
//           frame sequences for axis_vlan_ingress_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axis_vlan_ingress_arbiter;
  localparam int NP = 4;
  localparam int PB = 2;
`ifdef VLAN_INGRESS_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0][31:0] rx_tdata;
  logic [NP-1:0]       rx_tvalid, rx_tlast, rx_tuser, rx_tready;
  logic [31:0]         tx_tdata;
  logic                tx_tvalid, tx_tlast, tx_tuser, tx_tready;
  logic [NP-1:0][11:0] cfg_vlan;
  logic [NP-1:0]       cfg_dt, cfg_du;
  logic [11:0]         port_vlan;
  logic                drop_tagged, drop_untagged, busy;
  logic [PB-1:0]       active_port;

  always #5 clk = ~clk;

  axis_vlan_ingress_arbiter #(.NUM_PORTS(NP), .PORT_BITS(PB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .axi_rx_tdata(rx_tdata), .axi_rx_tvalid(rx_tvalid), .axi_rx_tlast(rx_tlast),
    .axi_rx_tuser(rx_tuser), .axi_rx_tready(rx_tready),
    .axi_tx_tdata(tx_tdata), .axi_tx_tvalid(tx_tvalid), .axi_tx_tlast(tx_tlast),
    .axi_tx_tuser(tx_tuser), .axi_tx_tready(tx_tready),
    .cfg_port_vlan(cfg_vlan), .cfg_drop_tagged(cfg_dt), .cfg_drop_untagged(cfg_du),
    .port_vlan(port_vlan), .drop_tagged(drop_tagged), .drop_untagged(drop_untagged),
    .active_port(active_port), .busy(busy)
  );

  typedef struct packed { logic [31:0] data; logic last; logic user; } beat_t;
  typedef struct packed { beat_t b; logic [PB-1:0] port; logic [11:0] vlan; logic dt; logic du; } exp_t;
  typedef struct { logic [NP-1:0] mask; logic user; int exp_port; } vec_t;

  beat_t         src_q [NP][$];
  exp_t          exp_q [$];
  logic [NP-1:0] src_en;
  logic          rnd_ready;
  logic [NP-1:0] rx_hs;
  logic          tx_hs;
  bit            gap_arm;
  int            gap_run;
  int            gaps [$];
  int            checks = 0;
  int            failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk(input int p, input int f, input int b);
    return {8'(p), 8'(f), 16'(b)};
  endfunction

  task automatic load_frame(input int p, input int f, input int n, input logic user_last);
    for (int b = 0; b < n; b++) begin
      beat_t x;
      x.data = mk(p, f, b);
      x.last = (b == n - 1);
      x.user = (b == n - 1) ? user_last : 1'b0;
      src_q[p].push_back(x);
    end
  endtask

  // Expected output beats [first, upto) of an n-beat frame, with the port's current cfg.
  task automatic expect_frame(input int p, input int f, input int first, input int upto,
                              input int n, input logic user_last);
    for (int b = first; b < upto; b++) begin
      exp_t e;
      e.b.data = mk(p, f, b);
      e.b.last = (b == n - 1);
      e.b.user = (b == n - 1) ? user_last : 1'b0;
      e.port   = PB'(p);
      e.vlan   = cfg_vlan[p];
      e.dt     = cfg_dt[p];
      e.du     = cfg_du[p];
      exp_q.push_back(e);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      if (src_q[i].size() > 0 && src_en[i]) begin
        rx_tvalid[i] = 1'b1;
        rx_tdata[i]  = src_q[i][0].data;
        rx_tlast[i]  = src_q[i][0].last;
        rx_tuser[i]  = src_q[i][0].user;
      end else begin
        rx_tvalid[i] = 1'b0;
        rx_tdata[i]  = '0;
        rx_tlast[i]  = 1'b0;
        rx_tuser[i]  = 1'b0;
      end
    end
    tx_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic step(input bit rel = 1'b0);
    exp_t e;
    @(negedge clk);
    drive();
    if (rel) rst = 1'b0;
    #4;
    rx_hs = rx_tvalid & rx_tready;
    tx_hs = tx_tvalid & tx_tready;
    if (tx_hs && tx_tlast) begin
      gap_arm = 1'b1;
      gap_run = 0;
    end else if (gap_arm) begin
      if (tx_tvalid) begin
        gaps.push_back(gap_run);
        gap_arm = 1'b0;
      end else begin
        gap_run++;
      end
    end
    if (tx_hs) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=%0h required=none", tx_tdata);
      end else begin
        e = exp_q.pop_front();
        check("tx_beat", {tx_tdata, tx_tlast, tx_tuser}, e.b);
        check("tx_port", active_port, e.port);
        check("tx_cfg", {port_vlan, drop_tagged, drop_untagged}, {e.vlan, e.dt, e.du});
      end
    end
    @(posedge clk);
    for (int i = 0; i < NP; i++)
      if (rx_hs[i]) void'(src_q[i].pop_front());
  endtask

  task automatic run_until_empty(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s_budget actual=%0d_left required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NP; i++) src_q[i].delete();
    exp_q.delete();
    drive();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [9];
    int   lat;
    rst = 1'b1;
    rnd_ready = 1'b0;
    tx_tready = 1'b1;
    src_en = '1;
    gap_arm = 1'b0;
    gap_run = 0;
    rx_tdata = '0; rx_tvalid = '0; rx_tlast = '0; rx_tuser = '0;
    for (int i = 0; i < NP; i++) begin
      cfg_vlan[i] = 12'(100 + 11 * i);
      cfg_dt[i]   = 1'(i & 1);
      cfg_du[i]   = 1'((i >> 1) & 1);
    end

    // Reset state, with every port requesting
    for (int i = 0; i < NP; i++) load_frame(i, 8'hF0, 1, 1'b0);
    @(negedge clk);
    drive();
    #4;
    check("rst_busy", busy, 0);
    check("rst_active_port", active_port, 0);
    check("rst_port_vlan", port_vlan, 0);
    check("rst_drops", {drop_tagged, drop_untagged}, 0);
    check("rst_rx_tready", rx_tready, 0);
    check("rst_tx_tvalid", tx_tvalid, 0);
    @(negedge clk);
    for (int i = 0; i < NP; i++) src_q[i].delete();
    drive();
    rst = 1'b0;

    // Arbitration table: single-beat frames, rr pointer evolves from 0
    vt[0] = '{4'b1111, 1'b0, 0};
    vt[1] = '{4'b1111, 1'b1, 1};
    vt[2] = '{4'b0001, 1'b0, 0};
    vt[3] = '{4'b1100, 1'b0, 2};
    vt[4] = '{4'b0110, 1'b1, 1};
    vt[5] = '{4'b1000, 1'b0, 3};
    vt[6] = '{4'b1010, 1'b0, 1};
    vt[7] = '{4'b0100, 1'b1, 2};
    vt[8] = '{4'b0111, 1'b0, 0};
    for (int r = 0; r < 9; r++) begin
      for (int i = 0; i < NP; i++) begin
        src_q[i].delete();
        if (vt[r].mask[i]) load_frame(i, r, 1, vt[r].user);
      end
      expect_frame(vt[r].exp_port, r, 0, 1, 1, vt[r].user);
      lat = 0;
      while (exp_q.size() > 0 && lat < 10) begin
        step();
        lat++;
      end
      check("arb_latency", lat, 2);
      exp_q.delete();
    end

    // Port 2, 16-beat frame, native VLAN 42
    for (int i = 0; i < NP; i++) src_q[i].delete();
    cfg_vlan[2] = 12'd42;
    load_frame(2, 1, 16, 1'b0);
    expect_frame(2, 1, 0, 16, 16, 1'b0);
    lat = 0;
    while (exp_q.size() == 16 && lat < 10) begin
      step();
      lat++;
    end
    check("p2_grant_latency", lat, 2);
    #1;
    check("p2_busy_mid", busy, 1);
    check("p2_port_vlan", port_vlan, 42);
    run_until_empty(40, "p2_frame");
    #1;
    check("p2_busy_after", busy, 0);

    // All ports, two back-to-back 8-beat frames each
    do_reset();
    gaps.delete();
    gap_arm = 1'b0;
    for (int i = 0; i < NP; i++) begin
      load_frame(i, 1, 8, 1'b0);
      load_frame(i, 2, 8, 1'b1);
    end
    for (int f = 1; f <= 2; f++)
      for (int i = 0; i < NP; i++) expect_frame(i, f, 0, 8, 8, f == 2);
    run_until_empty(200, "rr_frames");
    check("rr_gap_count", gaps.size(), 7);
    foreach (gaps[g]) check("rr_gap_len", gaps[g], 1);

    // Config change while a port-1 frame is in flight
    cfg_vlan[1] = 12'd10;
    cfg_dt[1]   = 1'b0;
    load_frame(1, 3, 8, 1'b0);
    load_frame(1, 4, 8, 1'b0);
    expect_frame(1, 3, 0, 8, 8, 1'b0);
    while (exp_q.size() > 5) step();
    cfg_vlan[1] = 12'd20;
    cfg_dt[1]   = 1'b1;
    expect_frame(1, 4, 0, 8, 8, 1'b0);
    run_until_empty(60, "cfg_change");

    // Random backpressure over a 64-beat frame with competing ports
    do_reset();
    rnd_ready = 1'b1;
    load_frame(0, 5, 64, 1'b0);
    for (int i = 1; i < NP; i++) load_frame(i, 5, 4, 1'b0);
    expect_frame(0, 5, 0, 64, 64, 1'b0);
    for (int i = 1; i < NP; i++) expect_frame(i, 5, 0, 4, 4, 1'b0);
    run_until_empty(600, "backpressure");
    rnd_ready = 1'b0;

    // Reset at beat 5 of a 10-beat port-3 frame
    do_reset();
    load_frame(3, 6, 10, 1'b0);
    expect_frame(3, 6, 0, 5, 10, 1'b0);
    run_until_empty(20, "p3_head");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_rx_tready", rx_tready, 0);
    check("midrst_port_vlan", port_vlan, 0);
    check("midrst_tx_tvalid", tx_tvalid, 0);
    load_frame(0, 7, 1, 1'b0);
    expect_frame(0, 7, 0, 1, 1, 1'b0);
    expect_frame(3, 6, 5, 10, 10, 1'b0);
    step(1'b1);
    run_until_empty(30, "post_rst");

`ifdef VLAN_INGRESS_ARB_TIMEOUT_EN
    // Port 0 stalls after beat 3; timeout closes the frame and drains it
    do_reset();
    load_frame(0, 8, 10, 1'b0);
    load_frame(1, 8, 2, 1'b0);
    expect_frame(0, 8, 0, 3, 10, 1'b0);
    run_until_empty(20, "to_head");
    src_en[0] = 1'b0;
    begin
      exp_t e;
      e.b.data = '0; e.b.last = 1'b1; e.b.user = 1'b1;
      e.port = '0; e.vlan = cfg_vlan[0]; e.dt = cfg_dt[0]; e.du = cfg_du[0];
      exp_q.push_back(e);
    end
    lat = 0;
    while (exp_q.size() > 0 && lat < 30) begin
      step();
      lat++;
    end
    check("to_err_beat_cycle", lat, 9);
    for (int c = lat; c < 20; c++) step();
    src_en[0] = 1'b1;
    expect_frame(1, 8, 0, 2, 2, 1'b0);
    run_until_empty(60, "to_drain");
    check("to_drained", src_q[0].size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
